ppu_vbuf_page_sched: RTL and testbench

Double-buffer page scheduler for the video buffer shared by the PPU writer and the LCD scan-out. It lives in the LCD clock domain and owns the page-select bit. It flips the LCD read page and the PPU write page only at an LCD frame boundary, and only after the PPU has completed a frame, so scan-out never tears. While a finished frame waits for the boundary, it throttles the PPU with a hold level and keeps frame-rate statistics.

---
 rtl/ppu_pkg.sv | 17 +
 rtl/ppu_toggle_sync.sv | 31 +++
 rtl/ppu_vbuf_page_sched.sv | 115 +++++++++++
 tb/tb_ppu_vbuf_page_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU video-buffer blocks: FSM encodings, default
// counter widths and the page-select reset value.
package ppu_pkg;

    localparam int unsigned VBS_W = 2;
    typedef logic [VBS_W-1:0] vbs_state_t;

    localparam vbs_state_t VBS_SHOW = 2'd0;
    localparam vbs_state_t VBS_PEND = 2'd1;
    localparam vbs_state_t VBS_SWAP = 2'd2;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned OVR_W_DEF = 8;

    localparam logic VBUF_PAGE_RST = 1'b1;

endpackage

// File: rtl/ppu_toggle_sync.sv
// Brings a toggle-encoded event into i_clk: 2-flop synchronizer, edge-detect
// flop, and a registered one-cycle pulse for each edge of i_tgl.
module ppu_toggle_sync (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_tgl,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_tgl;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync ^ r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/ppu_vbuf_page_sched.sv
// Double-buffer page scheduler: flips LCD/PPU pages only at an LCD frame
// boundary after a completed PPU frame, holds the PPU meanwhile, keeps stats.
module ppu_vbuf_page_sched
    import ppu_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned OVR_W = OVR_W_DEF
) (
    input  logic             i_lcd_clk,
    input  logic             i_lcd_rstn,
    input  logic             i_ppu_frame_tgl,
    input  logic             i_lcd_frame_end,
    input  logic             i_enable,
    output logic             o_lcd_page,
    output logic             o_ppu_page,
    output logic             o_ppu_hold,
    output logic [CNT_W-1:0] o_swap_cnt,
    output logic [CNT_W-1:0] o_repeat_cnt,
    output logic [OVR_W-1:0] o_ovr_cnt,
    output logic [1:0]       o_state
);

    logic             w_done_raw;
    logic             w_done;
    vbs_state_t       r_state;
    vbs_state_t       w_nxt;
    logic             w_flip;
    logic             w_rep_inc;
    logic             w_ovr_inc;
    logic             r_lcd_page;
    logic             r_hold;
    logic [CNT_W-1:0] r_swap_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [OVR_W-1:0] r_ovr_cnt;

    ppu_toggle_sync u_frame_sync (
        .i_clk   (i_lcd_clk),
        .i_rstn  (i_lcd_rstn),
        .i_tgl   (i_ppu_frame_tgl),
        .o_pulse (w_done_raw)
    );

    // The synchronizer keeps tracking while disabled; only its pulse is dropped.
    assign w_done = w_done_raw & i_enable;

    // State and registered outputs
    always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
        if (!i_lcd_rstn) begin
            r_state    <= VBS_SHOW;
            r_lcd_page <= VBUF_PAGE_RST;
            r_hold     <= 1'b0;
            r_swap_cnt <= '0;
            r_rep_cnt  <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            r_state <= w_nxt;
            r_hold  <= (w_nxt == VBS_PEND);
            if (w_flip) begin
                r_lcd_page <= ~r_lcd_page;
                r_swap_cnt <= r_swap_cnt + CNT_W'(1);
            end
            if (w_rep_inc && (r_rep_cnt != '1)) begin
                r_rep_cnt <= r_rep_cnt + CNT_W'(1);
            end
            if (w_ovr_inc && (r_ovr_cnt != '1)) begin
                r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
            end
        end
    end

    // Next state; SWAP behaves like SHOW so a done landing there is not lost
    always_comb begin
        w_nxt = r_state;
        if (!i_enable) begin
            w_nxt = VBS_SHOW;
        end else begin
            case (r_state)
                VBS_SHOW, VBS_SWAP: begin
                    if (w_done && i_lcd_frame_end) begin
                        w_nxt = VBS_SWAP;
                    end else if (w_done) begin
                        w_nxt = VBS_PEND;
                    end else begin
                        w_nxt = VBS_SHOW;
                    end
                end
                VBS_PEND: begin
                    if (i_lcd_frame_end) begin
                        w_nxt = VBS_SWAP;
                    end
                end
                default: w_nxt = VBS_SHOW;
            endcase
        end
    end

    // Update strobes for the page bit and statistics
    always_comb begin
        w_flip    = 1'b0;
        w_rep_inc = 1'b0;
        w_ovr_inc = 1'b0;
        w_flip    = (w_nxt == VBS_SWAP);
        w_rep_inc = i_lcd_frame_end & ~w_flip;
        w_ovr_inc = w_done & (r_state == VBS_PEND);
    end

    assign o_lcd_page   = r_lcd_page;
    assign o_ppu_page   = ~r_lcd_page;
    assign o_ppu_hold   = r_hold;
    assign o_swap_cnt   = r_swap_cnt;
    assign o_repeat_cnt = r_rep_cnt;
    assign o_ovr_cnt    = r_ovr_cnt;
    assign o_state      = r_state;

endmodule

// File: tb/tb_ppu_vbuf_page_sched.sv
// Directed self-checking bench for ppu_vbuf_page_sched.
module tb_ppu_vbuf_page_sched;

    logic        clk;
    logic        rstn;
    logic        tgl;
    logic        fe;
    logic        en;
    logic        lcd_page;
    logic        ppu_page;
    logic        hold;
    logic [15:0] swap_cnt;
    logic [15:0] rep_cnt;
    logic [7:0]  ovr_cnt;
    logic [1:0]  state;

    int checks;
    int failures;

    ppu_vbuf_page_sched dut (
        .i_lcd_clk       (clk),
        .i_lcd_rstn      (rstn),
        .i_ppu_frame_tgl (tgl),
        .i_lcd_frame_end (fe),
        .i_enable        (en),
        .o_lcd_page      (lcd_page),
        .o_ppu_page      (ppu_page),
        .o_ppu_hold      (hold),
        .o_swap_cnt      (swap_cnt),
        .o_repeat_cnt    (rep_cnt),
        .o_ovr_cnt       (ovr_cnt),
        .o_state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle; inputs change and outputs are sampled here.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fe();
        fe = 1'b1;
        step(1);
        fe = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; tgl = 1'b0; fe = 1'b0; en = 1'b1;
        step(3);
        rstn = 1'b1;
        step(1);
        checks++; if (lcd_page !== 1'b1) begin failures++; $display("FAIL reset_lcd_page got=%b exp=1", lcd_page); end
        checks++; if (ppu_page !== 1'b0) begin failures++; $display("FAIL reset_ppu_page got=%b exp=0", ppu_page); end
        checks++; if (hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", hold); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (swap_cnt !== 16'd0 || rep_cnt !== 16'd0 || ovr_cnt !== 8'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", swap_cnt, rep_cnt, ovr_cnt);
        end
    endtask

    task automatic test_normal_swap();
        tgl = ~tgl;
        step(3);
        checks++; if (hold !== 1'b0) begin failures++; $display("FAIL swap_hold_early got=%b exp=0", hold); end
        step(1);
        checks++; if (hold !== 1'b1 || state !== 2'd1) begin
            failures++; $display("FAIL swap_enter_pend got hold=%b state=%0d exp hold=1 state=1", hold, state);
        end
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++; if (hold !== 1'b1) begin failures++; $display("FAIL swap_hold_level cyc=%0d got=%b exp=1", i, hold); end
        end
        pulse_fe();
        checks++; if (state !== 2'd2 || lcd_page !== 1'b0 || ppu_page !== 1'b1) begin
            failures++; $display("FAIL swap_flip got state=%0d lcd=%b ppu=%b exp 2/0/1", state, lcd_page, ppu_page);
        end
        checks++; if (swap_cnt !== 16'd1 || hold !== 1'b0) begin
            failures++; $display("FAIL swap_cnt_hold got cnt=%0d hold=%b exp 1/0", swap_cnt, hold);
        end
        checks++; if (rep_cnt !== 16'd0) begin failures++; $display("FAIL swap_no_repeat got=%0d exp=0", rep_cnt); end
        step(1);
        checks++; if (state !== 2'd0 || lcd_page !== 1'b0) begin
            failures++; $display("FAIL swap_back_show got state=%0d lcd=%b exp 0/0", state, lcd_page);
        end
    endtask

    task automatic test_repeat();
        for (int i = 0; i < 3; i++) begin
            pulse_fe();
            step(1);
        end
        checks++; if (rep_cnt !== 16'd3) begin failures++; $display("FAIL repeat_cnt got=%0d exp=3", rep_cnt); end
        checks++; if (lcd_page !== 1'b0 || swap_cnt !== 16'd1 || state !== 2'd0) begin
            failures++; $display("FAIL repeat_pages got lcd=%b swap=%0d state=%0d exp 0/1/0", lcd_page, swap_cnt, state);
        end
    endtask

    task automatic test_simultaneous();
        tgl = ~tgl;
        step(3);
        fe = 1'b1;
        step(1);
        fe = 1'b0;
        checks++; if (state !== 2'd2 || hold !== 1'b0) begin
            failures++; $display("FAIL simul_direct got state=%0d hold=%b exp 2/0", state, hold);
        end
        checks++; if (lcd_page !== 1'b1 || swap_cnt !== 16'd2 || rep_cnt !== 16'd3) begin
            failures++; $display("FAIL simul_flip got lcd=%b swap=%0d rep=%0d exp 1/2/3", lcd_page, swap_cnt, rep_cnt);
        end
        step(1);
        checks++; if (state !== 2'd0 || hold !== 1'b0) begin
            failures++; $display("FAIL simul_settle got state=%0d hold=%b exp 0/0", state, hold);
        end
    endtask

    task automatic test_overrun();
        tgl = ~tgl;
        step(4);
        checks++; if (state !== 2'd1 || hold !== 1'b1) begin
            failures++; $display("FAIL ovr_pend got state=%0d hold=%b exp 1/1", state, hold);
        end
        for (int k = 0; k < 2; k++) begin
            tgl = ~tgl;
            step(4);
        end
        checks++; if (ovr_cnt !== 8'd2 || state !== 2'd1 || hold !== 1'b1) begin
            failures++; $display("FAIL ovr_count got ovr=%0d state=%0d hold=%b exp 2/1/1", ovr_cnt, state, hold);
        end
        pulse_fe();
        checks++; if (lcd_page !== 1'b0 || swap_cnt !== 16'd3) begin
            failures++; $display("FAIL ovr_flip got lcd=%b swap=%0d exp 0/3", lcd_page, swap_cnt);
        end
        step(1);
        pulse_fe();
        step(1);
        checks++; if (lcd_page !== 1'b0 || swap_cnt !== 16'd3 || rep_cnt !== 16'd4 || state !== 2'd0) begin
            failures++; $display("FAIL ovr_single_flip got lcd=%b swap=%0d rep=%0d state=%0d exp 0/3/4/0",
                                 lcd_page, swap_cnt, rep_cnt, state);
        end
    endtask

    task automatic test_disable();
        en = 1'b0;
        tgl = ~tgl;
        step(5);
        pulse_fe();
        step(1);
        checks++; if (lcd_page !== 1'b0 || hold !== 1'b0 || state !== 2'd0) begin
            failures++; $display("FAIL dis_no_flip got lcd=%b hold=%b state=%0d exp 0/0/0", lcd_page, hold, state);
        end
        checks++; if (swap_cnt !== 16'd3 || rep_cnt !== 16'd5) begin
            failures++; $display("FAIL dis_counts got swap=%0d rep=%0d exp 3/5", swap_cnt, rep_cnt);
        end
        en = 1'b1;
        step(6);
        checks++; if (state !== 2'd0 || hold !== 1'b0) begin
            failures++; $display("FAIL dis_reenable got state=%0d hold=%b exp 0/0", state, hold);
        end
    endtask

    task automatic test_reset_mid_pend();
        tgl = ~tgl;
        step(4);
        checks++; if (hold !== 1'b1 || lcd_page !== 1'b0) begin
            failures++; $display("FAIL midrst_pre got hold=%b lcd=%b exp 1/0", hold, lcd_page);
        end
        #2;
        rstn = 1'b0;
        tgl = 1'b0;
        #1;
        checks++; if (hold !== 1'b0 || lcd_page !== 1'b1 || ppu_page !== 1'b0) begin
            failures++; $display("FAIL midrst_async got hold=%b lcd=%b ppu=%b exp 0/1/0", hold, lcd_page, ppu_page);
        end
        checks++; if (state !== 2'd0 || swap_cnt !== 16'd0 || rep_cnt !== 16'd0 || ovr_cnt !== 8'd0) begin
            failures++; $display("FAIL midrst_clear got state=%0d swap=%0d rep=%0d ovr=%0d exp 0/0/0/0",
                                 state, swap_cnt, rep_cnt, ovr_cnt);
        end
        step(2);
        rstn = 1'b1;
        step(5);
        checks++; if (state !== 2'd0 || hold !== 1'b0 || lcd_page !== 1'b1) begin
            failures++; $display("FAIL midrst_release got state=%0d hold=%b lcd=%b exp 0/0/1", state, hold, lcd_page);
        end
    endtask

    task automatic test_repeat_saturation();
        fe = 1'b1;
        step(65535);
        checks++; if (rep_cnt !== 16'hFFFF) begin failures++; $display("FAIL repsat_reach got=%h exp=ffff", rep_cnt); end
        step(3);
        fe = 1'b0;
        checks++; if (rep_cnt !== 16'hFFFF || lcd_page !== 1'b1 || swap_cnt !== 16'd0) begin
            failures++; $display("FAIL repsat_hold got rep=%h lcd=%b swap=%0d exp ffff/1/0", rep_cnt, lcd_page, swap_cnt);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_normal_swap();
        test_repeat();
        test_simultaneous();
        test_overrun();
        test_disable();
        test_reset_mid_pend();
        test_repeat_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
